// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: arbitrates the single regfile write port between
// in-order ALU/link results (queued in a FIFO) and out-of-order load returns (always win),
// and keeps a per-register scoreboard that gates issue against RAW/WAW hazards.
module regfile_wb_scheduler #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned WB_DEPTH  = 4,
  parameter int unsigned MAX_LOADS = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [4:0]        iss_rs,
  input  logic [4:0]        iss_rt,
  input  logic [4:0]        iss_dst,
  input  logic [1:0]        iss_src,
  input  logic [DATA_W-1:0] iss_data,
  input  logic              ld_valid,
  input  logic [4:0]        ld_tag,
  input  logic [DATA_W-1:0] ld_data,
  output logic              wr_en,
  output logic [4:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [31:0]       pending,
  output logic              ld_err
);

  localparam int unsigned PtrW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(WB_DEPTH + 1);
  localparam int unsigned LdW  = $clog2(MAX_LOADS + 1);
  localparam logic [CntW-1:0] FifoFull = CntW'(WB_DEPTH);
  localparam logic [LdW-1:0]  LdMax    = LdW'(MAX_LOADS);
  localparam logic [PtrW-1:0] PtrLast  = PtrW'(WB_DEPTH - 1);

  logic [4:0]        fifo_dst_q  [WB_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [WB_DEPTH];
  logic [PtrW-1:0]   head_q, tail_q;
  logic [CntW-1:0]   fifo_cnt_q;
  logic [LdW-1:0]    ld_cnt_q;
  // Outstanding loads whose destination was r0; only these may legally return with tag 0.
  logic [LdW-1:0]    zld_cnt_q;
  logic [31:0]       pending_q, pending_d;
  logic [31:0]       ld_pend_q, ld_pend_d;
  logic              wr_en_q;
  logic [4:0]        wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              ld_err_q;

  logic hazard, is_alu, is_load, fifo_full, fifo_empty, accept;
  logic ld_hit, ld_zero, ld_bad, pop, push, sb_set, ld_inc, ld_dec, zld_inc;

  // Issue gating and write-port arbitration decisions.
  always_comb begin
    is_alu     = (iss_src == 2'd1) || (iss_src == 2'd3);
    is_load    = (iss_src == 2'd2);
    fifo_full  = (fifo_cnt_q == FifoFull);
    fifo_empty = (fifo_cnt_q == '0);
    hazard     = pending_q[iss_rs] | pending_q[iss_rt] |
                 ((iss_src != 2'd0) && pending_q[iss_dst]);
    iss_ready  = !hazard && !(is_load && (ld_cnt_q == LdMax)) && !(is_alu && fifo_full);
    accept     = iss_valid && iss_ready;
    ld_hit     = ld_valid && ld_pend_q[ld_tag];
    ld_zero    = ld_valid && !ld_hit && (ld_tag == 5'd0) && (zld_cnt_q != '0);
    ld_bad     = ld_valid && !ld_hit && !ld_zero;
    // Any load return owns the port this cycle, even an erroneous one.
    pop        = !ld_valid && !fifo_empty;
    push       = accept && is_alu && (iss_dst != 5'd0);
    sb_set     = accept && (iss_src != 2'd0) && (iss_dst != 5'd0);
    ld_inc     = accept && is_load;
    zld_inc    = accept && is_load && (iss_dst == 5'd0);
    ld_dec     = ld_hit || ld_zero;
  end

  // Scoreboard next state: clears from this cycle's write, then sets from this cycle's issue.
  always_comb begin
    pending_d = pending_q;
    ld_pend_d = ld_pend_q;
    if (ld_hit) begin
      pending_d[ld_tag] = 1'b0;
      ld_pend_d[ld_tag] = 1'b0;
    end
    if (pop) begin
      pending_d[fifo_dst_q[head_q]] = 1'b0;
    end
    if (sb_set) begin
      pending_d[iss_dst] = 1'b1;
      if (is_load) begin
        ld_pend_d[iss_dst] = 1'b1;
      end
    end
    pending_d[0] = 1'b0;
    ld_pend_d[0] = 1'b0;
  end

  // Control state, counters and registered write port.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      fifo_cnt_q <= '0;
      ld_cnt_q   <= '0;
      zld_cnt_q  <= '0;
      pending_q  <= '0;
      ld_pend_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      ld_err_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ld_pend_q <= ld_pend_d;
      if (push) begin
        tail_q <= (tail_q == PtrLast) ? '0 : tail_q + 1'b1;
      end
      if (pop) begin
        head_q <= (head_q == PtrLast) ? '0 : head_q + 1'b1;
      end
      if (push && !pop) begin
        fifo_cnt_q <= fifo_cnt_q + 1'b1;
      end else if (pop && !push) begin
        fifo_cnt_q <= fifo_cnt_q - 1'b1;
      end
      if (ld_inc && !ld_dec) begin
        ld_cnt_q <= ld_cnt_q + 1'b1;
      end else if (ld_dec && !ld_inc) begin
        ld_cnt_q <= ld_cnt_q - 1'b1;
      end
      if (zld_inc && !ld_zero) begin
        zld_cnt_q <= zld_cnt_q + 1'b1;
      end else if (ld_zero && !zld_inc) begin
        zld_cnt_q <= zld_cnt_q - 1'b1;
      end
      if (ld_bad) begin
        ld_err_q <= 1'b1;
      end
      if (ld_hit) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= ld_tag;
        wr_data_q <= ld_data;
      end else if (pop) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= fifo_dst_q[head_q];
        wr_data_q <= fifo_data_q[head_q];
      end else begin
        wr_en_q   <= 1'b0;
      end
    end
  end

  // FIFO payload storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_dst_q[tail_q]  <= iss_dst;
      fifo_data_q[tail_q] <= iss_data;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign pending = pending_q;
  assign ld_err  = ld_err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios plus randomized traffic,
// all compared against a queue-based behavioural model of the scheduling rules.
module tb_regfile_wb_scheduler;

  localparam int unsigned DW   = 32;
  localparam int unsigned DEP  = 4;
  localparam int unsigned MAXL = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          iss_valid = 1'b0;
  logic          iss_ready;
  logic [4:0]    iss_rs = '0, iss_rt = '0, iss_dst = '0;
  logic [1:0]    iss_src = '0;
  logic [DW-1:0] iss_data = '0;
  logic          ld_valid = 1'b0;
  logic [4:0]    ld_tag = '0;
  logic [DW-1:0] ld_data = '0;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic [31:0]   pending;
  logic          ld_err;

  regfile_wb_scheduler #(.DATA_W(DW), .WB_DEPTH(DEP), .MAX_LOADS(MAXL)) dut (
    .clock(clock), .reset_n(reset_n),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rs(iss_rs), .iss_rt(iss_rt),
    .iss_dst(iss_dst), .iss_src(iss_src), .iss_data(iss_data),
    .ld_valid(ld_valid), .ld_tag(ld_tag), .ld_data(ld_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pending(pending), .ld_err(ld_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: writeback queue, outstanding-write set, outstanding-load set.
  typedef struct { logic [4:0] dst; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  bit          mp[32];
  bit          mlp[32];
  int          mlc, mzc;
  bit          m_wen, m_err;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  task automatic m_reset();
    mq.delete();
    for (int r = 0; r < 32; r++) begin
      mp[r] = 0;
      mlp[r] = 0;
    end
    mlc = 0; mzc = 0; m_wen = 0; m_err = 0; m_waddr = '0; m_wdata = '0;
  endtask

  function automatic logic [31:0] m_pend_vec();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = mp[r];
    return v;
  endfunction

  function automatic bit m_ready(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] dst, input logic [1:0] src);
    if (mp[rs] || mp[rt] || (src != 0 && mp[dst])) return 0;
    if (src == 2 && mlc == MAXL) return 0;
    if ((src == 1 || src == 3) && mq.size() == DEP) return 0;
    return 1;
  endfunction

  task automatic m_step(input bit acc, input logic [4:0] dst, input logic [1:0] src,
                        input logic [31:0] data, input bit lv, input logic [4:0] tag,
                        input logic [31:0] ldat);
    ent_t e;
    m_wen = 0;
    if (lv) begin
      if (tag != 0 && mlp[tag]) begin
        m_wen = 1; m_waddr = tag; m_wdata = ldat;
        mp[tag] = 0; mlp[tag] = 0; mlc--;
      end else if (tag == 0 && mzc > 0) begin
        mzc--; mlc--;
      end else begin
        m_err = 1;
      end
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_wen = 1; m_waddr = e.dst; m_wdata = e.data;
      mp[e.dst] = 0;
    end
    if (acc) begin
      if (src == 2) begin
        mlc++;
        if (dst != 0) begin
          mp[dst] = 1; mlp[dst] = 1;
        end else begin
          mzc++;
        end
      end else if (src != 0 && dst != 0) begin
        e.dst = dst; e.data = data;
        mq.push_back(e);
        mp[dst] = 1;
      end
    end
  endtask

  task automatic check_outputs();
    check_val("wr_en", wr_en, m_wen);
    check_val("wr_addr", wr_addr, m_waddr);
    check_val("wr_data", wr_data, m_wdata);
    check_val("pending", pending, m_pend_vec());
    check_val("ld_err", ld_err, m_err);
  endtask

  // One clock: drive at negedge, check ready before the edge, check outputs after it.
  task automatic cycle(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] dst, input logic [1:0] src, input logic [31:0] data,
                       input bit lv, input logic [4:0] tag, input logic [31:0] ldat);
    bit r;
    @(negedge clock);
    iss_valid = v; iss_rs = rs; iss_rt = rt; iss_dst = dst; iss_src = src; iss_data = data;
    ld_valid = lv; ld_tag = tag; ld_data = ldat;
    #1;
    r = m_ready(rs, rt, dst, src);
    check_val("iss_ready", iss_ready, r);
    @(posedge clock);
    m_step(v && r, dst, src, data, lv, tag, ldat);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    iss_valid = 0; ld_valid = 0;
    #2 reset_n = 0;
    #1;
    m_reset();
    check_outputs();
    @(negedge clock);
    reset_n = 1;
  endtask

  task automatic random_phase(input int n, input int lv_pct, input int iss_pct);
    int cand[$];
    bit v, lv;
    logic [4:0] tag;
    for (int i = 0; i < n; i++) begin
      cand.delete();
      for (int r = 1; r < 32; r++) if (mlp[r]) cand.push_back(r);
      if (mzc > 0) cand.push_back(0);
      v  = ($urandom_range(0, 99) < iss_pct);
      lv = ($urandom_range(0, 99) < lv_pct) && (cand.size() > 0 || $urandom_range(0, 99) < 3);
      if (cand.size() > 0 && $urandom_range(0, 99) < 95)
        tag = 5'(cand[$urandom_range(0, cand.size() - 1)]);
      else
        tag = 5'($urandom_range(0, 31));
      cycle(v, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), $urandom, lv, tag, $urandom);
    end
  endtask

  initial begin
    m_reset();
    #3;
    check_outputs();
    @(negedge clock);
    reset_n = 1;

    // ALU result to an idle port is written on the next edge.
    cycle(1, 0, 0, 5, 1, 32'h1234, 0, 0, 0);
    check_val("alu_pending5", pending[5], 1'b1);
    idle(1);
    check_val("alu_write", {wr_en, wr_addr, wr_data}, {1'b1, 5'd5, 32'h1234});
    check_val("alu_pend_clr", pending[5], 1'b0);

    // RAW on an outstanding load stalls until the load is written.
    cycle(1, 0, 0, 8, 2, 0, 0, 0, 0);
    cycle(1, 8, 0, 9, 1, 32'h77, 0, 0, 0);
    check_val("raw_stall", iss_ready, 1'b0);
    cycle(1, 8, 0, 9, 1, 32'h77, 1, 8, 32'hCAFE);
    check_val("ld_write", {wr_en, wr_addr, wr_data}, {1'b1, 5'd8, 32'hCAFE});
    cycle(1, 8, 0, 9, 1, 32'h77, 0, 0, 0);
    idle(2);

    // Load and FIFO contend: load first, FIFO head next cycle.
    cycle(1, 0, 0, 12, 2, 0, 0, 0, 0);
    cycle(1, 0, 0, 3, 1, 32'hA5A5, 1, 12, 32'h5555);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val("fifo_after_ld", {wr_en, wr_addr, wr_data}, {1'b1, 5'd3, 32'hA5A5});
    idle(2);

    // Load limit, then r0 destinations (no write).
    cycle(1, 0, 0, 20, 2, 0, 0, 0, 0);
    cycle(1, 0, 0, 21, 2, 0, 0, 0, 0);
    cycle(1, 0, 0, 22, 2, 0, 0, 0, 0);
    check_val("max_loads", iss_ready, 1'b0);
    cycle(1, 0, 0, 22, 2, 0, 1, 20, 32'h1);
    cycle(1, 0, 0, 22, 2, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 32'hDEAD, 1, 21, 32'h2);
    cycle(0, 0, 0, 0, 0, 0, 1, 22, 32'h3);
    idle(2);
    cycle(1, 0, 0, 0, 2, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 32'h9);
    check_val("r0_load_no_err", ld_err, 1'b0);

    // Port blocked by bogus load returns: FIFO fills, 5th ALU issue stalls, then drains.
    for (int i = 1; i <= 4; i++) cycle(1, 0, 0, 5'(i), 1, 32'(100 + i), 1, 30, 0);
    cycle(1, 0, 0, 6, 3, 32'h600, 1, 30, 0);
    check_val("fifo_full", iss_ready, 1'b0);
    check_val("bad_ld_err", ld_err, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check_val("drain_order", {wr_addr, wr_data}, {5'(i), 32'(100 + i)});
    end
    idle(1);

    // Reset with results still queued.
    cycle(1, 0, 0, 7, 2, 0, 0, 0, 0);
    cycle(1, 0, 0, 2, 1, 32'h42, 1, 30, 0);
    do_reset();
    cycle(0, 0, 0, 0, 0, 0, 1, 7, 32'h5);
    check_val("stale_ld_err", ld_err, 1'b1);
    do_reset();

    random_phase(800, 20, 60);
    do_reset();
    random_phase(800, 60, 80);
    do_reset();
    random_phase(800, 85, 90);
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
